reset_controller: RTL and testbench

RESET_CONTROLLER -- requirements
Module: reset_controller

---
 rtl/reset_controller.sv | 134 +++++++++++++
 tb/tb_reset_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_controller.sv
// SoC reset sequencer: synchronizes and debounces a manual reset button,
// holds the SoC in reset for a fixed window, and drives status LEDs.
module reset_controller #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int HOLD_CYCLES     = 16,
    parameter int BLINK_BITS      = 23
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       button_n,
    input  logic       halt,
    output logic       soc_reset,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [1:0] state,
    output logic [7:0] reset_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PRESS = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic                  db_level_q, db_level_d;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    state_e                state_q, state_d;
    logic                  soc_reset_q, soc_reset_d;
    logic                  led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;
    logic [7:0]            reset_count_q, reset_count_d;
    logic                  press_evt, release_evt;

    // Debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        sync1_d    = button_n;
        sync2_d    = sync1_q;
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        press_evt   = db_level_q & ~db_level_d;
        release_evt = ~db_level_q & db_level_d;
        blink_d     = blink_q + BLINK_BITS'(1);
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        case (state_q)
            ST_HOLD: begin
                if (press_evt) begin
                    state_d = ST_PRESS;
                end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (press_evt)  state_d = ST_PRESS;
                else if (halt)  state_d = ST_HALT;
            end
            ST_HALT: begin
                if (press_evt)  state_d = ST_PRESS;
            end
            ST_PRESS: begin
                if (release_evt) state_d = ST_HOLD;
            end
            default: state_d = ST_HOLD;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        soc_reset_d = (state_d == ST_HOLD) || (state_d == ST_PRESS);
        led_r_d     = soc_reset_d;
        led_g_d     = (state_d == ST_RUN);
        led_b_d     = (state_d == ST_HALT) && blink_q[BLINK_BITS-1];

        reset_count_d = reset_count_q;
        if (state_d == ST_PRESS && state_q != ST_PRESS && reset_count_q != 8'hFF) begin
            reset_count_d = reset_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            db_level_q    <= 1'b1;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            blink_q       <= '0;
            state_q       <= ST_HOLD;
            soc_reset_q   <= 1'b1;
            led_r_q       <= 1'b1;
            led_g_q       <= 1'b0;
            led_b_q       <= 1'b0;
            reset_count_q <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_level_q    <= db_level_d;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            blink_q       <= blink_d;
            state_q       <= state_d;
            soc_reset_q   <= soc_reset_d;
            led_r_q       <= led_r_d;
            led_g_q       <= led_g_d;
            led_b_q       <= led_b_d;
            reset_count_q <= reset_count_d;
        end
    end

    assign soc_reset   = soc_reset_q;
    assign led_r       = led_r_q;
    assign led_g       = led_g_q;
    assign led_b       = led_b_q;
    assign state       = state_q;
    assign reset_count = reset_count_q;

endmodule

// File: tb/tb_reset_controller.sv
// Directed bench for reset_controller with short debounce/hold/blink parameters.
module tb_reset_controller;

    logic       clk_48mhz = 1'b0;
    logic       reset_n, button_n, halt;
    logic       soc_reset, led_r, led_g, led_b;
    logic [1:0] state;
    logic [7:0] reset_count;

    int n_vec = 0;
    int n_err = 0;

    reset_controller #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (3),
        .BLINK_BITS     (3)
    ) dut (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .button_n   (button_n),
        .halt       (halt),
        .soc_reset  (soc_reset),
        .led_r      (led_r),
        .led_g      (led_g),
        .led_b      (led_b),
        .state      (state),
        .reset_count(reset_count)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_48mhz);
            #1;
        end
    endtask

    // Press reaches PRESS 6 edges after button_n falls; release reaches HOLD
    // 6 edges after it rises; HOLD then lasts 3 edges.
    task automatic press_release();
        button_n = 1'b0;
        tick(7);
        button_n = 1'b1;
        tick(7);
        tick(3);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; button_n = 1'b1; halt = 1'b0;
        tick(2);
        n_vec++;
        if ({state, soc_reset, led_r, led_g, led_b, reset_count} !== {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: got state=%0d rst=%b rgb=%b%b%b cnt=%0d, want 0 1 100 0",
                     state, soc_reset, led_r, led_g, led_b, reset_count);
        end
        reset_n = 1'b1;
        tick(2);
        n_vec++;
        if (soc_reset !== 1'b1 || state !== 2'd0) begin
            n_err++;
            $display("FAIL powerup_hold: got rst=%b state=%0d after 2 edges, want 1 0", soc_reset, state);
        end
        tick(1);
        n_vec++;
        if ({state, soc_reset, led_r, led_g} !== {2'd1, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL powerup_run: got state=%0d rst=%b r=%b g=%b after 3 edges, want 1 0 0 1",
                     state, soc_reset, led_r, led_g);
        end
    endtask

    task automatic test_glitch();
        button_n = 1'b0;
        tick(3);
        button_n = 1'b1;
        tick(10);
        n_vec++;
        if ({state, soc_reset, reset_count} !== {2'd1, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL glitch: got state=%0d rst=%b cnt=%0d, want 1 0 0", state, soc_reset, reset_count);
        end
    endtask

    task automatic test_press();
        button_n = 1'b0;
        tick(5);
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL press_early: got state=%0d after 5 edges, want 1", state);
        end
        tick(1);
        n_vec++;
        if ({state, soc_reset, led_r, led_g, reset_count} !== {2'd2, 1'b1, 1'b1, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL press_enter: got state=%0d rst=%b r=%b g=%b cnt=%0d, want 2 1 1 0 1",
                     state, soc_reset, led_r, led_g, reset_count);
        end
        tick(4);
        button_n = 1'b1;
        tick(6);
        n_vec++;
        if (state !== 2'd0 || soc_reset !== 1'b1) begin
            n_err++;
            $display("FAIL release_hold: got state=%0d rst=%b, want 0 1", state, soc_reset);
        end
        tick(2);
        n_vec++;
        if (state !== 2'd0 || soc_reset !== 1'b1) begin
            n_err++;
            $display("FAIL hold_len: got state=%0d rst=%b 2 edges into HOLD, want 0 1", state, soc_reset);
        end
        tick(1);
        n_vec++;
        if ({state, soc_reset, led_g} !== {2'd1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL hold_exit: got state=%0d rst=%b g=%b, want 1 0 1", state, soc_reset, led_g);
        end
    endtask

    task automatic test_halt();
        logic lb [16];
        int   changes;
        bool_ok_block: begin
            bit ok;
            halt = 1'b1;
            tick(1);
            n_vec++;
            if ({state, soc_reset, led_r, led_g} !== {2'd3, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL halt_enter: got state=%0d rst=%b r=%b g=%b, want 3 0 0 0",
                         state, soc_reset, led_r, led_g);
            end
            for (int i = 0; i < 16; i++) begin
                lb[i] = led_b;
                tick(1);
            end
            ok = 1'b1;
            changes = 0;
            for (int i = 4; i < 16; i++) if (lb[i] === lb[i-4]) ok = 1'b0;
            for (int i = 1; i < 16; i++) if (lb[i] !== lb[i-1]) changes++;
            n_vec++;
            if (!ok || changes < 3 || changes > 4) begin
                n_err++;
                $display("FAIL blink: half-period-4 check=%b transitions=%0d, want 1 and 3..4", ok, changes);
            end
            halt = 1'b0;
            tick(3);
            n_vec++;
            if (state !== 2'd3) begin
                n_err++;
                $display("FAIL halt_sticky: got state=%0d after halt drop, want 3", state);
            end
            button_n = 1'b0;
            tick(7);
            n_vec++;
            if (state !== 2'd2 || reset_count !== 8'd2) begin
                n_err++;
                $display("FAIL halt_press: got state=%0d cnt=%0d, want 2 2", state, reset_count);
            end
            button_n = 1'b1;
            tick(10);
            n_vec++;
            if (state !== 2'd1) begin
                n_err++;
                $display("FAIL halt_recover: got state=%0d, want 1", state);
            end
        end
    endtask

    task automatic test_simultaneous();
        button_n = 1'b0;
        tick(5);
        halt = 1'b1;
        tick(1);
        n_vec++;
        if (state !== 2'd2 || reset_count !== 8'd3) begin
            n_err++;
            $display("FAIL press_vs_halt: got state=%0d cnt=%0d, want 2 3", state, reset_count);
        end
        tick(3);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL press_ignores_halt: got state=%0d, want 2", state);
        end
        halt = 1'b0;
        button_n = 1'b1;
        tick(10);
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL simul_recover: got state=%0d, want 1", state);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 252; i++) press_release();
        n_vec++;
        if (reset_count !== 8'd255) begin
            n_err++;
            $display("FAIL count_255: got cnt=%0d after 255 presses, want 255", reset_count);
        end
        press_release();
        n_vec++;
        if (reset_count !== 8'd255 || state !== 2'd1) begin
            n_err++;
            $display("FAIL count_sat: got cnt=%0d state=%0d after 256 presses, want 255 1", reset_count, state);
        end
    endtask

    task automatic test_midop_reset();
        button_n = 1'b0;
        tick(7);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL midop_pre: got state=%0d, want 2", state);
        end
        reset_n = 1'b0;
        tick(1);
        n_vec++;
        if ({state, soc_reset, led_r, led_g, led_b, reset_count} !== {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL midop_reset: got state=%0d rst=%b rgb=%b%b%b cnt=%0d, want 0 1 100 0",
                     state, soc_reset, led_r, led_g, led_b, reset_count);
        end
        reset_n = 1'b1;
        tick(3);
        n_vec++;
        if (state !== 2'd1 || reset_count !== 8'd0) begin
            n_err++;
            $display("FAIL held_run: got state=%0d cnt=%0d 3 edges after reset, want 1 0", state, reset_count);
        end
        tick(2);
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL held_early: got state=%0d 5 edges after reset, want 1", state);
        end
        tick(1);
        n_vec++;
        if (state !== 2'd2 || reset_count !== 8'd1 || soc_reset !== 1'b1) begin
            n_err++;
            $display("FAIL held_press: got state=%0d cnt=%0d rst=%b, want 2 1 1", state, reset_count, soc_reset);
        end
        button_n = 1'b1;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_halt();
        test_simultaneous();
        test_saturation();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
